// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the frame sources, the arbiter and the shared UART transmitter.
// master: sources + transmitter side (drives requests and tx_busy).
// slave:  the arbiter (drives grant/done/error and the transmitter command).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*15-1:0] req_num_bytes;
    logic [NUM_REQ*8-1:0]  req_data;
    logic [NUM_REQ*2-1:0]  req_delay;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic                  error;
    logic                  tx_start;
    logic [14:0]           tx_num_bytes;
    logic [1:0]            tx_delay;
    logic [7:0]            tx_data;
    logic                  tx_busy;

    modport master (
        output req, req_num_bytes, req_data, req_delay, tx_busy,
        input  grant, done, error, tx_start, tx_num_bytes, tx_delay, tx_data
    );

    modport slave (
        input  req, req_num_bytes, req_data, req_delay, tx_busy,
        output grant, done, error, tx_start, tx_num_bytes, tx_delay, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ
// frame sources. One owner at a time; its length and delay are latched at
// arbitration and its live data byte is muxed onto tx_data.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing owned, waiting for any request
// ARB       | pick next requester from rr_ptr, latch its frame parameters
// START     | issue the single tx_start pulse
// WAIT_BUSY | wait for transmitter busy to rise, bounded by timeout timer
// WAIT_DONE | frame in flight, wait for busy to fall
// GAP       | idle spacing between frames before re-arbitration
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic              system_clock,
    input  logic              rst,
    input  logic              clock_enable,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(BUSY_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    // A zero gap skips the GAP state entirely.
    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               error_q;
    logic               tx_start_q;
    logic [14:0]        num_bytes_q;
    logic [1:0]         delay_q;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;
    logic [14:0]        pick_len;
    logic [1:0]         pick_delay;
    logic [NUM_REQ-1:0] pick_onehot;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Round-robin search: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_valid && bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Parameters of the candidate, captured only when the FSM is in ARB.
    always_comb begin
        pick_len    = bus.req_num_bytes[int'(pick_idx) * 15 +: 15];
        pick_delay  = bus.req_delay[int'(pick_idx) * 2 +: 2];
        pick_onehot = NUM_REQ'(1) << pick_idx;
    end

    // Sequencer FSM with its timeout and gap down-counters; pulses last one enabled cycle.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            error_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            num_bytes_q <= '0;
            delay_q     <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else if (clock_enable) begin
            done_q     <= '0;
            error_q    <= 1'b0;
            tx_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    grant_q <= '0;
                    if (|bus.req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (pick_valid) begin
                        owner       <= pick_idx;
                        num_bytes_q <= pick_len;
                        delay_q     <= pick_delay;
                        grant_q     <= pick_onehot;
                        if (pick_len == 15'd0) begin
                            done_q  <= pick_onehot;
                            rr_ptr  <= next_ptr(pick_idx);
                            gap_cnt <= GAP_LOAD;
                            state   <= AFTER_FRAME;
                        end else begin
                            state <= START;
                        end
                    end else begin
                        // Request vanished between IDLE and ARB.
                        state <= IDLE;
                    end
                end
                START: begin
                    tx_start_q <= 1'b1;
                    to_cnt     <= TO_LOAD;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt <= TO_W'(1)) begin
                        to_cnt  <= '0;
                        error_q <= 1'b1;
                        done_q  <= grant_q;
                        grant_q <= '0;
                        rr_ptr  <= next_ptr(owner);
                        gap_cnt <= GAP_LOAD;
                        state   <= AFTER_FRAME;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        rr_ptr  <= next_ptr(owner);
                        gap_cnt <= GAP_LOAD;
                        state   <= AFTER_FRAME;
                    end
                end
                GAP: begin
                    grant_q <= '0;
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_num_bytes = num_bytes_q;
    assign bus.tx_delay     = delay_q;
    assign bus.tx_data      = bus.req_data[int'(owner) * 8 +: 8];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int GAP = 4;
    localparam int BT  = 8;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    bit   ce_slow = 1'b0;
    bit   dead    = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .system_clock (clk),
        .rst          (rst),
        .clock_enable (ce),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // event logs, indexed by enabled-cycle sample number
    int ecyc = 0;
    int g_val[$], g_cyc[$], d_val[$], d_cyc[$], e_cyc[$], s_cyc[$];
    int bytes_seen = 0;
    int seen_data  = 0;
    int n_model    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_en(input int k);
        int c = 0;
        while (c < k) begin
            @(posedge clk);
            if (ce) c++;
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        g_val.delete(); g_cyc.delete(); d_val.delete(); d_cyc.delete();
        e_cyc.delete(); s_cyc.delete();
        bytes_seen = 0;
    endtask

    task automatic set_src(input int i, input int len, input int dly, input int data);
        bus.req_num_bytes[i*15 +: 15] = 15'(len);
        bus.req_delay[i*2 +: 2]       = 2'(dly);
        bus.req_data[i*8 +: 8]        = 8'(data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        step(3);
        rst = 1'b0;
        step(2);
        clear_logs();
    endtask

    task automatic wait_grants(input string tag, input int n, input int budget);
        int c = 0;
        while (g_val.size() < n && c < budget) begin
            step(1);
            c++;
        end
        chk(tag, g_val.size(), n);
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int c = 0;
        while (d_val.size() < n && c < budget) begin
            step(1);
            c++;
        end
        chk(tag, d_val.size(), n);
    endtask

    // Five round-robin frames with all sources requesting.
    task automatic run_rr(input string tag);
        do_reset();
        for (int i = 0; i < NR; i++) set_src(i, 1, 0, 16 + i);
        bus.req = 4'b1111;
        wait_grants({tag, "_grants"}, 5, 3000);
        bus.req = '0;
        wait_dones({tag, "_dones"}, 5, 3000);
        for (int k = 0; k < 5 && k < g_val.size(); k++) begin
            chk($sformatf("%s_grant%0d", tag, k), g_val[k], 1 << (k % NR));
            chk($sformatf("%s_done%0d", tag, k), d_val[k], 1 << (k % NR));
            if (k > 0) chk($sformatf("%s_gap%0d", tag, k), g_cyc[k] - d_cyc[k-1], GAP + 2);
        end
        chk({tag, "_starts"}, s_cyc.size(), 5);
    endtask

    // enable generator: always on, or one enabled cycle in four
    initial begin
        int ph = 0;
        ce = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ce_slow) begin
                ce = (ph == 0);
                ph = (ph + 1) % 4;
            end else begin
                ce = 1'b1;
                ph = 0;
            end
        end
    end

    // monitor: one sample per enabled cycle, just before the enabled edge
    initial begin
        logic [NR-1:0] prev_g = '0;
        forever begin
            @(negedge clk);
            if (ce) begin
                ecyc++;
                if (bus.grant != 0 && prev_g == 0) begin
                    g_val.push_back(int'(bus.grant));
                    g_cyc.push_back(ecyc);
                end
                prev_g = bus.grant;
                if (bus.done != 0) begin
                    d_val.push_back(int'(bus.done));
                    d_cyc.push_back(ecyc);
                end
                if (bus.error) e_cyc.push_back(ecyc);
                if (bus.tx_start) s_cyc.push_back(ecyc);
            end
        end
    end

    // transmitter model: busy one enabled cycle after start, two enabled cycles per byte
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start && !dead && !rst) begin
                n_model = int'(bus.tx_num_bytes);
                wait_en(1);
                bus.tx_busy = 1'b1;
                for (int b = 0; b < n_model; b++) begin
                    seen_data = int'(bus.tx_data);
                    bytes_seen++;
                    wait_en(2);
                end
                bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_num_bytes = '0;
        bus.req_data      = '0;
        bus.req_delay     = '0;
        do_reset();

        // reset state
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_start", int'(bus.tx_start), 0);
        chk("rst_len", int'(bus.tx_num_bytes), 0);
        chk("rst_delay", int'(bus.tx_delay), 0);

        // single 3-byte frame from source 0
        set_src(0, 3, 2, 8'hA5);
        bus.req = 4'b0001;
        step(1);
        chk("t1_grant_p1", int'(bus.grant), 0);
        step(1);
        chk("t1_grant_p2", int'(bus.grant), 1);
        chk("t1_len", int'(bus.tx_num_bytes), 3);
        chk("t1_delay", int'(bus.tx_delay), 2);
        chk("t1_start_p2", int'(bus.tx_start), 0);
        step(1);
        chk("t1_start_p3", int'(bus.tx_start), 1);
        chk("t1_data", int'(bus.tx_data), 8'hA5);
        step(1);
        chk("t1_start_p4", int'(bus.tx_start), 0);
        wait_dones("t1_done_wait", 1, 200);
        chk("t1_done", int'(bus.done), 1);
        chk("t1_grant_clr", int'(bus.grant), 0);
        bus.req = '0;
        step(4);
        chk("t1_bytes", bytes_seen, 3);
        chk("t1_seen_data", seen_data, 8'hA5);
        chk("t1_starts", s_cyc.size(), 1);
        chk("t1_done_once", d_val.size(), 1);
        chk("t1_no_err", e_cyc.size(), 0);

        // round robin, full-rate enable
        run_rr("t2");

        // zero-length frame on source 2, then rr pointer lands on 3
        do_reset();
        set_src(2, 0, 1, 8'h22);
        bus.req = 4'b0100;
        wait_dones("t3_done_wait", 1, 100);
        bus.req = '0;
        chk("t3_grant", g_val.size() > 0 ? g_val[0] : -1, 4);
        chk("t3_done", d_val[0], 4);
        chk("t3_same_cycle", g_cyc.size() > 0 ? g_cyc[0] : -1, d_cyc[0]);
        chk("t3_no_start", s_cyc.size(), 0);
        step(GAP + 2);
        set_src(0, 1, 0, 8'h10);
        set_src(3, 1, 0, 8'h13);
        bus.req = 4'b1001;
        wait_grants("t3_next_wait", 2, 100);
        bus.req = '0;
        chk("t3_next_grant", g_val[g_val.size()-1], 8);
        wait_dones("t3_next_done_wait", 2, 200);
        chk("t3_next_done", d_val[d_val.size()-1], 8);

        // busy never rises: timeout, then recovery with rr past the owner
        dead = 1'b1;
        do_reset();
        set_src(1, 2, 0, 8'h11);
        bus.req = 4'b0010;
        wait_dones("t4_done_wait", 1, 200);
        bus.req = '0;
        chk("t4_done", d_val[0], 2);
        chk("t4_err_cnt", e_cyc.size(), 1);
        chk("t4_err_time", (e_cyc.size() > 0 && s_cyc.size() > 0) ? e_cyc[0] - s_cyc[0] : -1, BT);
        chk("t4_err_done_align", e_cyc.size() > 0 ? e_cyc[0] : -1, d_cyc[0]);
        dead = 1'b0;
        step(GAP + 4);
        chk("t4_idle_grant", int'(bus.grant), 0);
        set_src(3, 1, 0, 8'h33);
        bus.req = 4'b1010;
        wait_grants("t4_rec_wait", 2, 200);
        bus.req = '0;
        chk("t4_rec_grant", g_val[g_val.size()-1], 8);
        wait_dones("t4_rec_done_wait", 2, 200);
        chk("t4_rec_done", d_val[d_val.size()-1], 8);
        chk("t4_rec_err", e_cyc.size(), 1);

        // same round robin with clock_enable at one cycle in four
        ce_slow = 1'b1;
        run_rr("t5");
        ce_slow = 1'b0;
        step(2);

        // reset in the middle of a frame
        do_reset();
        set_src(0, 3, 1, 8'h5A);
        begin
            int c = 0;
            bus.req = 4'b0001;
            while (!bus.tx_busy && c < 100) begin
                step(1);
                c++;
            end
            chk("t6_busy_seen", int'(bus.tx_busy), 1);
        end
        step(1);
        chk("t6_owned", int'(bus.grant), 1);
        rst = 1'b1;
        bus.req = '0;
        step(1);
        chk("t6_rst_grant", int'(bus.grant), 0);
        chk("t6_rst_start", int'(bus.tx_start), 0);
        chk("t6_rst_len", int'(bus.tx_num_bytes), 0);
        rst = 1'b0;
        begin
            int c = 0;
            while (bus.tx_busy && c < 100) begin
                step(1);
                c++;
            end
            chk("t6_busy_fall", int'(bus.tx_busy), 0);
        end
        step(3);
        chk("t6_idle_grant", int'(bus.grant), 0);
        clear_logs();
        set_src(2, 1, 3, 8'h77);
        bus.req = 4'b0100;
        wait_dones("t6_new_done_wait", 1, 200);
        bus.req = '0;
        chk("t6_new_grant", g_val.size() > 0 ? g_val[0] : -1, 4);
        chk("t6_new_done", d_val[0], 4);
        chk("t6_new_bytes", bytes_seen, 1);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
